// File: rtl/ahb_master_port_if.sv
// Command/response and AHB-lite signal bundle for one initiator port.
// master = the port itself, slave = local logic plus the bus fabric.
interface ahb_master_port_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [2:0]    cmd_size;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          hreq;
  logic          hgrant;
  logic [3:0]    sel;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [DW-1:0] hwdata;
  logic [DW-1:0] hrdata;
  logic          hready;
  logic          hresp;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_size,
    input  hgrant, hrdata, hready, hresp,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output hreq, sel, haddr, htrans, hwrite, hsize, hwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_size,
    output hgrant, hrdata, hready, hresp,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  hreq, sel, haddr, htrans, hwrite, hsize, hwdata
  );
endinterface

// File: rtl/ahb_master_port.sv
// Single-beat AHB-lite initiator: arbitration request, address/data phases,
// response pulse, and a per-state watchdog that aborts stuck transfers.
module ahb_master_port #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic hclk,
  input  logic hresetn,
  ahb_master_port_if.master bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, ADDR, DATA} state_e;

  typedef struct packed {
    logic          write;
    logic [2:0]    size;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  cmd_t          cmd_q, cmd_d;
  logic          hreq_q, hreq_d;
  logic [3:0]    sel_q, sel_d;
  logic [AW-1:0] haddr_q, haddr_d;
  logic [1:0]    htrans_q, htrans_d;
  logic          hwrite_q, hwrite_d;
  logic [2:0]    hsize_q, hsize_d;
  logic [DW-1:0] hwdata_q, hwdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;
  logic          expired, abort;

  // Counter saturates one short of TIMEOUT: this cycle is the TIMEOUT-th in the state.
  assign expired = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    hreq_d      = hreq_q;
    sel_d       = sel_q;
    haddr_d     = haddr_q;
    htrans_d    = htrans_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    hwdata_d    = hwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    abort       = 1'b0;
    case (state_q)
      IDLE: if (bus.cmd_valid) begin
        cmd_d   = '{write: bus.cmd_write, size: bus.cmd_size,
                    addr: bus.cmd_addr, wdata: bus.cmd_wdata};
        state_d = REQ;
        hreq_d  = 1'b1;
        sel_d   = 4'b0001 << bus.cmd_addr[AW-1 -: 2];
      end
      REQ: if (bus.hgrant) begin
        state_d  = ADDR;
        haddr_d  = cmd_q.addr;
        hwrite_d = cmd_q.write;
        hsize_d  = cmd_q.size;
        htrans_d = 2'b10;
      end else if (expired) abort = 1'b1;
      ADDR: if (bus.hready) begin
        state_d  = DATA;
        htrans_d = 2'b00;
        if (cmd_q.write) hwdata_d = cmd_q.wdata;
      end else if (!bus.hgrant) begin
        state_d  = REQ;
        htrans_d = 2'b00;
      end else if (expired) abort = 1'b1;
      DATA: if (bus.hready) begin
        // hresp with hready low is only the first ERROR cycle; sample on hready.
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_err_d   = bus.hresp;
        if (!cmd_q.write) rsp_rdata_d = bus.hrdata;
        hreq_d      = 1'b0;
        sel_d       = 4'b0000;
      end else if (expired) abort = 1'b1;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d     = IDLE;
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
      hreq_d      = 1'b0;
      htrans_d    = 2'b00;
      sel_d       = 4'b0000;
    end
    cnt_d = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_q       <= '0;
      hreq_q      <= 1'b0;
      sel_q       <= '0;
      haddr_q     <= '0;
      htrans_q    <= 2'b00;
      hwrite_q    <= 1'b0;
      hsize_q     <= '0;
      hwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      hreq_q      <= hreq_d;
      sel_q       <= sel_d;
      haddr_q     <= haddr_d;
      htrans_q    <= htrans_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      hwdata_q    <= hwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.hreq      = hreq_q;
  assign bus.sel       = sel_q;
  assign bus.haddr     = haddr_q;
  assign bus.htrans    = htrans_q;
  assign bus.hwrite    = hwrite_q;
  assign bus.hsize     = hsize_q;
  assign bus.hwdata    = hwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_ahb_master_port.sv
// Directed bench for ahb_master_port: main instance (TIMEOUT=32) and a
// short-watchdog instance (TIMEOUT=8) for the abort path.
module tb_ahb_master_port;
  logic hclk, hresetn;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_rdata = '0;

  ahb_master_port_if #(.AW(32), .DW(32)) bus ();
  ahb_master_port_if #(.AW(32), .DW(32)) bus2 ();

  ahb_master_port #(.AW(32), .DW(32), .TIMEOUT(32)) dut (
    .hclk(hclk), .hresetn(hresetn), .bus(bus));
  ahb_master_port #(.AW(32), .DW(32), .TIMEOUT(8)) dut_t (
    .hclk(hclk), .hresetn(hresetn), .bus(bus2));

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  // One single-beat transfer; gdly = cycles from hreq to grant, waits = data-phase wait states.
  task automatic txn(input string tag, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] rdata,
                     input logic [2:0] size, input int gdly, input int waits,
                     input logic err);
    logic [3:0] esel;
    int cyc;
    esel = 4'b0001 << addr[31:30];
    cyc  = 0;
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = addr;
    bus.cmd_wdata = wdata; bus.cmd_size = size;
    bus.hgrant = 1'b0; bus.hready = 1'b1; bus.hresp = 1'b0; bus.hrdata = rdata;
    chk({tag, " cmd_ready"}, bus.cmd_ready, 1);
    step(); cyc++;
    bus.cmd_valid = 1'b0;
    chk({tag, " hreq"}, bus.hreq, 1);
    chk({tag, " sel"}, bus.sel, esel);
    chk({tag, " busy"}, bus.cmd_ready, 0);
    repeat (gdly) begin
      step(); cyc++;
      chk({tag, " req htrans"}, bus.htrans, 2'b00);
      chk({tag, " req hreq/sel"}, {bus.hreq, bus.sel}, {1'b1, esel});
    end
    bus.hgrant = 1'b1;
    step(); cyc++;
    chk({tag, " addr htrans"}, bus.htrans, 2'b10);
    chk({tag, " haddr"}, bus.haddr, addr);
    chk({tag, " hwrite/hsize"}, {bus.hwrite, bus.hsize}, {wr, size});
    step(); cyc++;
    chk({tag, " data htrans"}, bus.htrans, 2'b00);
    if (wr) chk({tag, " hwdata"}, bus.hwdata, wdata);
    repeat (waits) begin
      bus.hready = 1'b0; bus.hresp = err;
      step(); cyc++;
      chk({tag, " wait rsp_valid"}, bus.rsp_valid, 0);
      chk({tag, " wait hreq"}, bus.hreq, 1);
      if (wr) chk({tag, " hwdata held"}, bus.hwdata, wdata);
    end
    bus.hready = 1'b1; bus.hresp = err;
    step(); cyc++;
    if (!wr) exp_rdata = rdata;
    bus.hresp = 1'b0; bus.hgrant = 1'b0;
    chk({tag, " rsp_valid"}, bus.rsp_valid, 1);
    chk({tag, " latency"}, cyc, 5 + (gdly - 1) + waits);
    chk({tag, " rsp_err"}, bus.rsp_err, err);
    chk({tag, " rsp_rdata"}, bus.rsp_rdata, exp_rdata);
    chk({tag, " release"}, {bus.hreq, bus.sel, bus.cmd_ready}, {1'b0, 4'b0000, 1'b1});
    step();
    chk({tag, " pulse"}, bus.rsp_valid, 0);
  endtask

  initial begin
    hresetn = 1'b0;
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.cmd_size = '0; bus.hgrant = 0; bus.hrdata = '0; bus.hready = 1; bus.hresp = 0;
    bus2.cmd_valid = 0; bus2.cmd_write = 0; bus2.cmd_addr = '0; bus2.cmd_wdata = '0;
    bus2.cmd_size = '0; bus2.hgrant = 0; bus2.hrdata = '0; bus2.hready = 1; bus2.hresp = 0;
    #12;
    chk("reset bus", {bus.hreq, bus.sel, bus.htrans, bus.hwrite, bus.hsize}, '0);
    chk("reset addr/data", {bus.haddr, bus.hwdata}, '0);
    chk("reset rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, '0);
    chk("reset cmd_ready", bus.cmd_ready, 1);
    step();
    hresetn = 1'b1;
    step();

    txn("t1 read", 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 3'd2, 1, 0, 1'b0);
    txn("t2 write", 1'b1, 32'h4000_0004, 32'h1234_5678, 32'h0BAD_0BAD, 3'd2, 1, 3, 1'b0);
    txn("t3 gdly", 1'b0, 32'hC000_0000, 32'h0, 32'h0F0F_1234, 3'd1, 10, 0, 1'b0);
    txn("t4 error", 1'b0, 32'h8000_0008, 32'h0, 32'h5555_AAAA, 3'd0, 1, 1, 1'b1);

    // Watchdog: grant never comes, abort after 8 cycles in REQ.
    bus2.cmd_valid = 1'b1; bus2.cmd_addr = 32'h4000_0000;
    step();
    bus2.cmd_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      chk("t5 req hold", {bus2.hreq, bus2.rsp_valid}, {1'b1, 1'b0});
      if (i < 8) step();
    end
    step();
    chk("t5 abort rsp", {bus2.rsp_valid, bus2.rsp_err}, 2'b11);
    chk("t5 abort rdata", bus2.rsp_rdata, 32'h0);
    chk("t5 abort bus", {bus2.hreq, bus2.sel, bus2.htrans}, '0);
    chk("t5 ready", bus2.cmd_ready, 1);
    bus2.cmd_valid = 1'b1;
    step();
    bus2.cmd_valid = 1'b0;
    chk("t5 next cmd", {bus2.hreq, bus2.sel}, {1'b1, 4'b0010});

    // Reset while a write sits in its data phase.
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 32'h8000_0020;
    bus.cmd_wdata = 32'hA5A5_5A5A; bus.cmd_size = 3'd2; bus.hready = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    step();
    bus.hgrant = 1'b1;
    step();
    step();
    bus.hready = 1'b0;
    chk("t6 in data", bus.hwdata, 32'hA5A5_5A5A);
    step();
    #2 hresetn = 1'b0;
    #1;
    chk("t6 async bus", {bus.hreq, bus.sel, bus.htrans, bus.hwrite, bus.hsize}, '0);
    chk("t6 async addr/data", {bus.haddr, bus.hwdata}, '0);
    chk("t6 async rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, '0);
    chk("t6 async ready", bus.cmd_ready, 1);
    bus.hgrant = 1'b0; bus.hready = 1'b1;
    step();
    hresetn = 1'b1;
    step();
    chk("t6 no rsp", bus.rsp_valid, 0);
    exp_rdata = '0;
    txn("t6 fresh", 1'b0, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 3'd2, 1, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
